// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the pipeline controller: stall masks, reset/stop levels,
// the ERET exception code and the controller state encoding.
package pipeline_ctrl_pkg;

   localparam logic RstEnable = 1'b1;
   localparam logic Stop      = 1'b1;
   localparam logic NoStop    = 1'b0;

   // bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
   localparam logic [5:0] StallMaskMem  = 6'b011111;
   localparam logic [5:0] StallMaskEx   = 6'b001111;
   localparam logic [5:0] StallMaskId   = 6'b000111;
   localparam logic [5:0] StallMaskIf   = 6'b000011;
   localparam logic [5:0] StallMaskNone = 6'b000000;

   localparam logic [31:0] ExcEret = 32'h0000_000e;

   typedef enum logic {
      CtrlRun   = 1'b0,
      CtrlDrain = 1'b1
   } ctrl_state_e;

   // The deepest stage requesting a stall freezes itself and everything upstream.
   function automatic logic [5:0] stall_mask(input logic req_mem, input logic req_ex,
                                             input logic req_id, input logic req_if);
      if (req_mem == Stop)     return StallMaskMem;
      else if (req_ex == Stop) return StallMaskEx;
      else if (req_id == Stop) return StallMaskId;
      else if (req_if == Stop) return StallMaskIf;
      else                     return StallMaskNone;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating event counter: counts inc cycles, holds at all-ones, clr wins over inc.
// One cycle latency from event to count; no backpressure.
module sat_counter
   import pipeline_ctrl_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr)
         count_d = '0;
      else if (inc && !(&count_q))
         count_d = count_q + WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (rst == RstEnable)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: merges stall requests, turns MEM exceptions into flush+redirect,
// drains a stale in-flight fetch after a flush. Outputs are zero-latency; counters lag one cycle.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020,
   parameter int          STALL_CNT_W = 32,
   parameter int          FLUSH_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stallreq_from_if,
   input  logic                   stallreq_from_id,
   input  logic                   stallreq_from_ex,
   input  logic                   stallreq_from_mem,
   input  logic [31:0]            excepttype_i,
   input  logic [31:0]            cp0_epc_i,
   input  logic                   cnt_clr,
   output logic [5:0]             stall,
   output logic                   flush,
   output logic [31:0]            new_pc,
   output logic                   if_discard,
   output logic [STALL_CNT_W-1:0] stall_cycles_o,
   output logic [FLUSH_CNT_W-1:0] flush_count_o
);

   ctrl_state_e state_q;
   ctrl_state_e state_d;

   always_comb begin
      stall      = StallMaskNone;
      flush      = 1'b0;
      new_pc     = 32'h0;
      if_discard = 1'b0;
      state_d    = state_q;
      if (rst == RstEnable) begin
         state_d = CtrlRun;
      end else if (excepttype_i != 32'h0) begin
         flush      = 1'b1;
         new_pc     = (excepttype_i == ExcEret) ? cp0_epc_i : EXC_VECTOR;
         // A stale fetch already in DRAIN is still outstanding, so keep dropping it.
         if_discard = (state_q == CtrlDrain);
         if (state_q == CtrlRun && stallreq_from_if == Stop)
            state_d = CtrlDrain;
      end else if (state_q == CtrlDrain) begin
         stall      = StallMaskIf;
         if_discard = 1'b1;
         if (stallreq_from_if == NoStop)
            state_d = CtrlRun;
      end else begin
         stall = stall_mask(stallreq_from_mem, stallreq_from_ex,
                            stallreq_from_id, stallreq_from_if);
      end
   end

   always_ff @(posedge clk) begin
      if (rst == RstEnable)
         state_q <= CtrlRun;
      else
         state_q <= state_d;
   end

   sat_counter #(.WIDTH(STALL_CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall != StallMaskNone),
      .clr   (cnt_clr),
      .count (stall_cycles_o)
   );

   sat_counter #(.WIDTH(FLUSH_CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (flush),
      .clr   (cnt_clr),
      .count (flush_count_o)
   );

endmodule
